// File: rtl/alu_seq.sv
// alu_seq: multi-cycle WIDTH-bit ALU with start/done handshake, registered result and C/V/H/Z/N flags.
// Define ALU_SEQ_DECIMAL_EN to build the nibble-serial BCD SUM/SUB path (DEC state); otherwise i_decimal is ignored.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  input  logic             i_decimal,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_half_carry,
  output logic             o_zero,
  output logic             o_negative
);

  localparam logic [2:0] OP_SUM = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_EOR = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SRS = 3'b101;
  localparam logic [2:0] OP_SLS = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_SEQ_DECIMAL_EN
    DEC  = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, ovf_q, half_q, zero_q, neg_q;

  // Single-cycle binary datapath, evaluated directly on the live operands
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_full;
  logic [3:0]       low_sum_unused;
  logic             add_h, add_v;
  logic [WIDTH-1:0] bin_r;
  logic             bin_c, bin_v, bin_h;

  always_comb begin
    b_eff    = (i_op == OP_SUB) ? ~i_b : i_b;
    add_full = {1'b0, i_a} + {1'b0, b_eff} + (WIDTH+1)'(i_carry);
    {add_h, low_sum_unused} = {1'b0, i_a[3:0]} + {1'b0, b_eff[3:0]} + 5'(i_carry);
    add_v    = (i_a[WIDTH-1] == b_eff[WIDTH-1]) & (add_full[WIDTH-1] != i_a[WIDTH-1]);
    bin_r    = '0;
    bin_c    = 1'b0;
    bin_v    = 1'b0;
    bin_h    = 1'b0;
    case (i_op)
      OP_SUM, OP_SUB: begin
        bin_r = add_full[WIDTH-1:0];
        bin_c = add_full[WIDTH];
        bin_v = add_v;
        bin_h = add_h;
      end
      OP_AND: bin_r = i_a & i_b;
      OP_EOR: bin_r = i_a ^ i_b;
      OP_OR:  bin_r = i_a | i_b;
      OP_SRS: begin
        bin_r = {i_carry, i_a[WIDTH-1:1]};
        bin_c = i_a[0];
      end
      OP_SLS: begin
        bin_r = {i_a[WIDTH-2:0], i_carry};
        bin_c = i_a[WIDTH-1];
      end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_DECIMAL_EN
  localparam int NIBS = WIDTH / 4;
  localparam int NW   = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [NW-1:0] LAST_NIB = NW'(NIBS - 1);

  // One BCD digit step; returns {carry_out, digit}. Non-BCD digits simply wrap mod 16.
  function automatic logic [4:0] bcd_nib(input logic [3:0] a, input logic [3:0] b,
                                         input logic cin, input logic sub);
    logic [5:0] s;
    logic       cout;
    if (sub) begin
      s = {2'b00, a} - {2'b00, b} - 6'(~cin);
      cout = ~s[5];
      if (s[5]) s = s + 6'd10;
    end else begin
      s = {2'b00, a} + {2'b00, b} + 6'(cin);
      cout = (s > 6'd9);
      if (cout) s = s + 6'd6;
    end
    return {cout, s[3:0]};
  endfunction

  logic             dec_req;
  logic [NW-1:0]    nib_q;
  logic [WIDTH-1:0] a_q, b_q, dres_q, dres_d;
  logic             dc_q, sub_q, dh_q, dv_q;
  logic [4:0]       nib_out;

  assign dec_req = i_decimal & ((i_op == OP_SUM) | (i_op == OP_SUB));

  always_comb begin
    nib_out = bcd_nib(4'(a_q >> {nib_q, 2'b00}), 4'(b_q >> {nib_q, 2'b00}), dc_q, sub_q);
    dres_d  = dres_q | (WIDTH'(nib_out[3:0]) << {nib_q, 2'b00});
  end

  // Operand latches and digit carry chain; pure datapath, no reset needed
  always_ff @(posedge i_clk) begin
    if (state_q == IDLE && i_start) begin
      a_q    <= i_a;
      b_q    <= i_b;
      dc_q   <= i_carry;
      sub_q  <= (i_op == OP_SUB);
      dv_q   <= bin_v;
      dres_q <= '0;
    end else if (state_q == DEC) begin
      dc_q   <= nib_out[4];
      dres_q <= dres_d;
      if (nib_q == '0) dh_q <= nib_out[4];
    end
  end
`else
  logic decimal_unused;
  assign decimal_unused = i_decimal;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      half_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
`ifdef ALU_SEQ_DECIMAL_EN
      nib_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            busy_q <= 1'b1;
`ifdef ALU_SEQ_DECIMAL_EN
            if (dec_req) begin
              state_q <= DEC;
              nib_q   <= '0;
            end else
`endif
            begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= bin_r;
              carry_q  <= bin_c;
              ovf_q    <= bin_v;
              half_q   <= bin_h;
              zero_q   <= (bin_r == '0);
              neg_q    <= bin_r[WIDTH-1];
            end
          end
        end
`ifdef ALU_SEQ_DECIMAL_EN
        DEC: begin
          nib_q <= nib_q + NW'(1);
          if (nib_q == LAST_NIB) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            nib_q    <= '0;
            result_q <= dres_d;
            carry_q  <= nib_out[4];
            ovf_q    <= dv_q;
            half_q   <= (nib_q == '0) ? nib_out[4] : dh_q;
            zero_q   <= (dres_d == '0);
            neg_q    <= dres_d[WIDTH-1];
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_result     = result_q;
  assign o_carry      = carry_q;
  assign o_overflow   = ovf_q;
  assign o_half_carry = half_q;
  assign o_zero       = zero_q;
  assign o_negative   = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: 8-bit and 16-bit instances, directed vectors with hand-computed results.
// Expectations for decimal vectors follow whether ALU_SEQ_DECIMAL_EN is defined.
module tb_alu_seq;

`ifdef ALU_SEQ_DECIMAL_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s8 = 1'b0, c8 = 1'b0, d8 = 1'b0;
  logic [2:0]  op8 = 3'd0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        bz8, dn8, fc8, fv8, fh8, fz8, fn8;
  logic [7:0]  r8;
  logic [4:0]  f8;

  logic        s16 = 1'b0, c16 = 1'b0, d16 = 1'b0;
  logic [2:0]  op16 = 3'd0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        bz16, dn16, fc16, fv16, fh16, fz16, fn16;
  logic [15:0] r16;
  logic [4:0]  f16;

  assign f8  = {fc8, fv8, fh8, fz8, fn8};
  assign f16 = {fc16, fv16, fh16, fz16, fn16};

  alu_seq #(.WIDTH(8)) u8 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(s8), .i_op(op8), .i_a(a8), .i_b(b8),
    .i_carry(c8), .i_decimal(d8), .o_busy(bz8), .o_done(dn8), .o_result(r8),
    .o_carry(fc8), .o_overflow(fv8), .o_half_carry(fh8), .o_zero(fz8), .o_negative(fn8)
  );

  alu_seq #(.WIDTH(16)) u16 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(s16), .i_op(op16), .i_a(a16), .i_b(b16),
    .i_carry(c16), .i_decimal(d16), .o_busy(bz16), .o_done(dn16), .o_result(r16),
    .o_carry(fc16), .o_overflow(fv16), .o_half_carry(fh16), .o_zero(fz16), .o_negative(fn16)
  );

  typedef struct {
    logic [15:0] r;
    logic [4:0]  f;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic score(input exp_t e, input logic [15:0] r, input logic [4:0] f, input logic busy);
    chk({e.name, " result"}, 32'(r), 32'(e.r));
    chk({e.name, " flags CVHZN"}, 32'(f), 32'(e.f));
    chk({e.name, " latency"}, 32'(cyc - e.t0), 32'(e.lat));
    chk({e.name, " busy at done"}, 32'(busy), 32'd1);
  endtask

  // Monitors: pop the oldest expectation whenever a done pulse appears
  initial forever begin
    @(negedge clk);
    if (dn8 === 1'b1) begin
      if (q8.size() == 0) chk("w8 unexpected done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        score(e, 16'(r8), f8, bz8);
        @(negedge clk);
        chk({e.name, " done/busy drop"}, 32'({dn8, bz8}), 32'd0);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (dn16 === 1'b1) begin
      if (q16.size() == 0) chk("w16 unexpected done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q16.pop_front();
        score(e, r16, f16, bz16);
        @(negedge clk);
        chk({e.name, " done/busy drop"}, 32'({dn16, bz16}), 32'd0);
      end
    end
  end

  task automatic wait8;
    int n = 0;
    while (q8.size() != 0 && n < 30) begin @(negedge clk); n++; end
    if (q8.size() != 0) begin
      chk("w8 done timeout", 32'(q8.size()), 32'd0);
      q8.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait16;
    int n = 0;
    while (q16.size() != 0 && n < 30) begin @(negedge clk); n++; end
    if (q16.size() != 0) begin
      chk("w16 done timeout", 32'(q16.size()), 32'd0);
      q16.delete();
    end
    @(negedge clk);
  endtask

  // Operands are scrambled right after acceptance; hold keeps i_start high (reserved op) one more edge.
  task automatic issue8(input string nm, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic dec, input logic [7:0] er, input logic [4:0] ef,
                        input int lat, input bit hold);
    exp_t e;
    e.name = nm; e.r = 16'(er); e.f = ef; e.lat = lat; e.t0 = cyc;
    q8.push_back(e);
    op8 = op; a8 = a; b8 = b; c8 = c; d8 = dec; s8 = 1'b1;
    @(posedge clk); #1;
    a8 = ~a; b8 = ~b; c8 = ~c;
    if (hold) begin
      op8 = 3'b111;
      @(posedge clk); #1;
    end
    s8 = 1'b0;
    wait8();
  endtask

  task automatic issue16(input string nm, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic dec, input logic [15:0] er, input logic [4:0] ef,
                         input int lat, input bit hold);
    exp_t e;
    e.name = nm; e.r = er; e.f = ef; e.lat = lat; e.t0 = cyc;
    q16.push_back(e);
    op16 = op; a16 = a; b16 = b; c16 = c; d16 = dec; s16 = 1'b1;
    @(posedge clk); #1;
    a16 = ~a; b16 = ~b; c16 = ~c;
    if (hold) begin
      op16 = 3'b111;
      @(posedge clk); #1;
    end
    s16 = 1'b0;
    wait16();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("w8 reset outputs", 32'({bz8, dn8, r8, f8}), 32'd0);
    chk("w16 reset outputs", 32'({bz16, dn16, r16, f16}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // flags are {C,V,H,Z,N}
    issue8("sum 7F+01", 3'b000, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 5'b01101, 1, 1'b0);
    issue8("dsum 58+46", 3'b000, 8'h58, 8'h46, 1'b1, 1'b1,
           DEC_EN ? 8'h05 : 8'h9F, DEC_EN ? 5'b11100 : 5'b01001, DEC_EN ? 3 : 1, 1'b1);
    issue8("dsub 12-21", 3'b001, 8'h12, 8'h21, 1'b1, 1'b1,
           DEC_EN ? 8'h91 : 8'hF1, 5'b00101, DEC_EN ? 3 : 1, 1'b0);
    issue8("srs 81", 3'b101, 8'h81, 8'h00, 1'b1, 1'b0, 8'hC0, 5'b10001, 1, 1'b0);
    issue8("sls 81", 3'b110, 8'h81, 8'h00, 1'b0, 1'b1, 8'h02, 5'b10000, 1, 1'b0);
    issue8("and F0&3C", 3'b010, 8'hF0, 8'h3C, 1'b1, 1'b1, 8'h30, 5'b00000, 1, 1'b0);
    issue8("eor A5^A5", 3'b011, 8'hA5, 8'hA5, 1'b0, 1'b0, 8'h00, 5'b00010, 1, 1'b0);
    issue8("or 0F|80", 3'b100, 8'h0F, 8'h80, 1'b0, 1'b0, 8'h8F, 5'b00001, 1, 1'b0);
    issue8("reserved", 3'b111, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 5'b00010, 1, 1'b0);
    issue8("sub 50-50", 3'b001, 8'h50, 8'h50, 1'b1, 1'b0, 8'h00, 5'b10110, 1, 1'b0);
    issue8("sub 00-01 borrow", 3'b001, 8'h00, 8'h01, 1'b0, 1'b0, 8'hFE, 5'b00001, 1, 1'b0);
    issue8("sum 80+80 held", 3'b000, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 5'b11010, 1, 1'b1);

    issue16("w16 dsum 9999+0001", 3'b000, 16'h9999, 16'h0001, 1'b0, 1'b1,
            DEC_EN ? 16'h0000 : 16'h999A, DEC_EN ? 5'b10110 : 5'b00001, DEC_EN ? 5 : 1, 1'b1);
    issue16("w16 sls 8001", 3'b110, 16'h8001, 16'h0000, 1'b1, 1'b0, 16'h0003, 5'b10000, 1, 1'b0);

    // Reset in the middle of a decimal operation (binary builds finish it first)
    if (DEC_EN) begin
      op8 = 3'b000; a8 = 8'h58; b8 = 8'h46; c8 = 1'b1; d8 = 1'b1; s8 = 1'b1;
      @(posedge clk); #1;
      s8 = 1'b0;
      @(posedge clk); #2;
    end else begin
      issue8("pre-reset dsum", 3'b000, 8'h58, 8'h46, 1'b1, 1'b1, 8'h9F, 5'b01001, 1, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    chk("w8 outputs in reset", 32'({bz8, dn8, r8, f8}), 32'd0);
    chk("w16 outputs in reset", 32'({bz16, dn16, r16, f16}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("w8 idle after reset", 32'({bz8, dn8, r8, f8}), 32'd0);

    issue8("dsum after reset", 3'b000, 8'h58, 8'h46, 1'b1, 1'b1,
           DEC_EN ? 8'h05 : 8'h9F, DEC_EN ? 5'b11100 : 5'b01001, DEC_EN ? 3 : 1, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
